// File: rtl/pc_redirect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_redirect_pkg: shared types and helpers for the PC redirect unit.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pc_redirect_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // The 33-bit sum keeps the carry so an overflowing add clamps instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_unit_mispredict_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mispredict_select: oldest-lane priority pick of mispredicted lanes.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mispredict_select #(
  parameter int LANES    = 2,
  parameter int PC_WIDTH = 11,
  parameter int IDX_W    = 1
) (
  input  logic [LANES-1:0]          mis_i,
  input  logic [LANES*PC_WIDTH-1:0] corr_pc_i,
  output logic                      any_mis_o,
  output logic [IDX_W-1:0]          win_idx_o,
  output logic [PC_WIDTH-1:0]       sel_pc_o,
  output logic [LANES-1:0]          younger_o
);

  always_comb begin
    win_idx_o = '0;
    // Descending scan so the lowest (oldest) mispredicting lane is the last write.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mis_i[i]) win_idx_o = IDX_W'(i);
    end
    any_mis_o = |mis_i;
    sel_pc_o  = corr_pc_i[int'(win_idx_o)*PC_WIDTH +: PC_WIDTH];
    younger_o = '0;
    for (int i = 0; i < LANES; i++) begin
      younger_o[i] = any_mis_o && (i > int'(win_idx_o));
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_redirect_unit: branch resolution, single redirect, flush, stats.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter int PC_WIDTH  = 11,
  parameter int LANES     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES-1:0]          lane_valid,
  input  logic [LANES-1:0]          lane_is_branch,
  input  logic [LANES-1:0]          lane_prediction,
  input  logic [LANES-1:0]          lane_taken,
  input  logic [LANES*PC_WIDTH-1:0] lane_pc_plus1,
  input  logic [LANES*PC_WIDTH-1:0] lane_target,
  output logic                      redirect_valid,
  output logic [PC_WIDTH-1:0]       redirect_pc,
  input  logic                      redirect_ready,
  output logic [LANES-1:0]          flush_lanes,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      branch_count,
  output logic [CNT_WIDTH-1:0]      mispredict_count
);

  localparam int          IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int          POP_W   = $clog2(LANES + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  logic [LANES-1:0]          w_mis;
  logic [LANES*PC_WIDTH-1:0] w_corr_pc;
  logic                      w_any_mis;
  logic [IDX_W-1:0]          w_unused_win_idx;
  logic [PC_WIDTH-1:0]       w_sel_pc;
  logic [LANES-1:0]          w_younger;
  logic [LANES-1:0]          w_counted;
  logic [POP_W-1:0]          w_pop;
  logic [CNT_WIDTH-1:0]      branch_cnt_d;
  logic [CNT_WIDTH-1:0]      mis_cnt_d;

  state_t                    state_q;
  logic                      redirect_valid_q;
  logic [PC_WIDTH-1:0]       redirect_pc_q;
  logic [LANES-1:0]          flush_q;
  logic                      busy_q;
  logic [CNT_WIDTH-1:0]      branch_cnt_q;
  logic [CNT_WIDTH-1:0]      mis_cnt_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_mis[i] = lane_valid[i] & lane_is_branch[i] & (lane_taken[i] ^ lane_prediction[i]);
    assign w_corr_pc[i*PC_WIDTH +: PC_WIDTH] = lane_taken[i] ? lane_target[i*PC_WIDTH +: PC_WIDTH]
                                                             : lane_pc_plus1[i*PC_WIDTH +: PC_WIDTH];
  end

  mispredict_select #(
    .LANES   (LANES),
    .PC_WIDTH(PC_WIDTH),
    .IDX_W   (IDX_W)
  ) u_select (
    .mis_i    (w_mis),
    .corr_pc_i(w_corr_pc),
    .any_mis_o(w_any_mis),
    .win_idx_o(w_unused_win_idx),
    .sel_pc_o (w_sel_pc),
    .younger_o(w_younger)
  );

  // Branches younger than the winning mispredict are wrong-path and not counted.
  assign w_counted    = lane_valid & lane_is_branch & ~w_younger;
  assign w_pop        = POP_W'(popcount(32'(w_counted)));
  assign branch_cnt_d = CNT_WIDTH'(sat_add(32'(branch_cnt_q), 32'(w_pop), CNT_MAX));
  assign mis_cnt_d    = CNT_WIDTH'(sat_add(32'(mis_cnt_q), 32'd1, CNT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= '0;
      busy_q           <= 1'b0;
      branch_cnt_q     <= '0;
      mis_cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          branch_cnt_q <= branch_cnt_d;
          if (w_any_mis) begin
            state_q          <= PENDING;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= w_sel_pc;
            flush_q          <= w_younger;
            busy_q           <= 1'b1;
            mis_cnt_q        <= mis_cnt_d;
          end else begin
            flush_q <= '0;
          end
        end
        PENDING: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= '0;
            busy_q           <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
          flush_q          <= '0;
          busy_q           <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush_lanes      = flush_q;
  assign busy             = busy_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_redirect_unit: vector table plus scoreboard for the redirect.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pc_redirect_unit;

  localparam int PCW  = 11;
  localparam int LN   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  logic [LN-1:0]   lane_valid, lane_is_branch, lane_prediction, lane_taken;
  logic [LN*PCW-1:0] lane_pc_plus1, lane_target;
  logic            redirect_valid, redirect_ready, busy;
  logic [PCW-1:0]  redirect_pc;
  logic [LN-1:0]   flush_lanes;
  logic [CW-1:0]   branch_count, mispredict_count;

  pc_redirect_unit #(.PC_WIDTH(PCW), .LANES(LN), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lane_valid      (lane_valid),
    .lane_is_branch  (lane_is_branch),
    .lane_prediction (lane_prediction),
    .lane_taken      (lane_taken),
    .lane_pc_plus1   (lane_pc_plus1),
    .lane_target     (lane_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_ready  (redirect_ready),
    .flush_lanes     (flush_lanes),
    .busy            (busy),
    .branch_count    (branch_count),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v, br, pr, tk;
    logic [10:0] pc0, pc1, tg0, tg1;
    logic        ev;
    logic [10:0] epc;
    logic [1:0]  efl;
    int          db;
    int          dm;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [10:0] pc;
    logic [1:0]  flush;
    logic        busy;
    int          bcnt;
    int          mcnt;
    logic        chk_pc;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_b    = 0;
  int   exp_m    = 0;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  function automatic vec_t mk(input logic [1:0] v, br, pr, tk,
                              input logic [10:0] pc0, pc1, tg0, tg1,
                              input logic ev, input logic [10:0] epc,
                              input logic [1:0] efl, input int db, dm);
    vec_t r;
    r.v = v; r.br = br; r.pr = pr; r.tk = tk;
    r.pc0 = pc0; r.pc1 = pc1; r.tg0 = tg0; r.tg1 = tg1;
    r.ev = ev; r.epc = epc; r.efl = efl; r.db = db; r.dm = dm;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] v, br, pr, tk,
                       input logic [10:0] pc0, pc1, tg0, tg1);
    lane_valid = v; lane_is_branch = br; lane_prediction = pr; lane_taken = tk;
    lane_pc_plus1 = {pc1, pc0};
    lane_target   = {tg1, tg0};
  endtask

  task automatic idle_lanes();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 11'h0, 11'h0, 11'h0, 11'h0);
  endtask

  task automatic push(input logic valid, input logic [10:0] pc, input logic [1:0] fl,
                      input logic bsy, input logic chk_pc);
    exp_t e;
    e.valid = valid; e.pc = pc; e.flush = fl; e.busy = bsy;
    e.bcnt = exp_b; e.mcnt = exp_m; e.chk_pc = chk_pc;
    exp_q.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, int'(redirect_valid), int'(e.valid));
    if (e.chk_pc) chk({tag, "_pc"}, int'(redirect_pc), int'(e.pc));
    chk({tag, "_flush"}, int'(flush_lanes), int'(e.flush));
    chk({tag, "_busy"}, int'(busy), int'(e.busy));
    chk({tag, "_bcnt"}, int'(branch_count), e.bcnt);
    chk({tag, "_mcnt"}, int'(mispredict_count), e.mcnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_b = 0; exp_m = 0;
    push(1'b0, 11'h0, 2'b00, 1'b0, 1'b1);
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_ready = 1'b0;
    idle_lanes();

    //            v      br     pr     tk     pc0     pc1     tg0     tg1    ev   epc     efl   db dm
    vecs[0] = mk(2'b01, 2'b01, 2'b00, 2'b01, 11'h001, 11'h002, 11'h120, 11'h0AA, 1, 11'h120, 2'b10, 1, 1);
    vecs[1] = mk(2'b10, 2'b10, 2'b10, 2'b00, 11'h003, 11'h045, 11'h0BB, 11'h0CC, 1, 11'h045, 2'b00, 1, 1);
    vecs[2] = mk(2'b11, 2'b11, 2'b10, 2'b01, 11'h004, 11'h200, 11'h010, 11'h0DD, 1, 11'h010, 2'b10, 1, 1);
    vecs[3] = mk(2'b11, 2'b10, 2'b00, 2'b11, 11'h005, 11'h006, 11'h111, 11'h333, 1, 11'h333, 2'b00, 1, 1);
    vecs[4] = mk(2'b11, 2'b11, 2'b01, 2'b01, 11'h007, 11'h008, 11'h222, 11'h444, 0, 11'h000, 2'b00, 2, 0);
    vecs[5] = mk(2'b01, 2'b11, 2'b01, 2'b11, 11'h009, 11'h00A, 11'h0EE, 11'h0FF, 0, 11'h000, 2'b00, 1, 0);
    vecs[6] = mk(2'b01, 2'b01, 2'b01, 2'b00, 11'h7FF, 11'h00B, 11'h123, 11'h124, 1, 11'h7FF, 2'b10, 1, 1);

    do_reset();

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].br, vecs[i].pr, vecs[i].tk,
            vecs[i].pc0, vecs[i].pc1, vecs[i].tg0, vecs[i].tg1);
      exp_b = sat(exp_b + vecs[i].db);
      exp_m = sat(exp_m + vecs[i].dm);
      push(vecs[i].ev, vecs[i].epc, vecs[i].efl, vecs[i].ev, vecs[i].ev);
      step();
      compare($sformatf("vec%0d", i));
      idle_lanes();
      if (vecs[i].ev) begin
        redirect_ready = 1'b1;
        push(1'b0, 11'h0, 2'b00, 1'b0, 1'b0);
        step();
        compare($sformatf("vec%0d_ack", i));
        redirect_ready = 1'b0;
      end
    end

    // Held redirect under back-pressure; lane inputs during PENDING must be ignored.
    drive(2'b10, 2'b10, 2'b10, 2'b00, 11'h001, 11'h045, 11'h002, 11'h003);
    exp_b = sat(exp_b + 1);
    exp_m = sat(exp_m + 1);
    push(1'b1, 11'h045, 2'b00, 1'b1, 1'b1);
    step();
    compare("hold_issue");
    drive(2'b01, 2'b01, 2'b00, 2'b01, 11'h001, 11'h002, 11'h555, 11'h003);
    for (int c = 0; c < 3; c++) begin
      push(1'b1, 11'h045, 2'b00, 1'b1, 1'b1);
      step();
      compare($sformatf("hold%0d", c));
    end
    redirect_ready = 1'b1;
    push(1'b0, 11'h0, 2'b00, 1'b0, 1'b0);
    step();
    compare("hs_ignore");
    redirect_ready = 1'b0;
    idle_lanes();
    push(1'b0, 11'h0, 2'b00, 1'b0, 1'b0);
    step();
    compare("no_second");

    // Counter saturation with two correctly predicted branches per cycle.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(2'b11, 2'b11, 2'b10, 2'b10, 11'h010, 11'h011, 11'h020, 11'h021);
      exp_b = sat(exp_b + 2);
      push(1'b0, 11'h0, 2'b00, 1'b0, 1'b0);
      step();
      compare($sformatf("sat%0d", c));
    end
    idle_lanes();

    // Asynchronous reset while a redirect is pending.
    drive(2'b01, 2'b01, 2'b00, 2'b01, 11'h001, 11'h002, 11'h3AB, 11'h003);
    exp_m = sat(exp_m + 1);
    exp_b = sat(exp_b + 1);
    push(1'b1, 11'h3AB, 2'b10, 1'b1, 1'b1);
    step();
    compare("pre_arst");
    idle_lanes();
    #2;
    rst_n = 1'b0;
    #1;
    exp_b = 0; exp_m = 0;
    push(1'b0, 11'h0, 2'b00, 1'b0, 1'b1);
    compare("arst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
